// File: rtl/ext_int_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ext_int_pkg
// Description : Shared constants for the Port D external / pin-change
//               interrupt controller: sense-control encodings and default
//               register addresses.
// Revision    : 1.0 - initial release
// ============================================================================
package ext_int_pkg;

  // Interrupt sense control (ISCn1:0) encodings
  localparam logic [1:0] ISC_LOW  = 2'b00;
  localparam logic [1:0] ISC_ANY  = 2'b01;
  localparam logic [1:0] ISC_FALL = 2'b10;
  localparam logic [1:0] ISC_RISE = 2'b11;

  // Default register addresses (I/O space and extended data space)
  localparam logic [5:0] DEF_EIFR_ADR   = 6'h1C;
  localparam logic [5:0] DEF_EIMSK_ADR  = 6'h1D;
  localparam logic [5:0] DEF_PCIFR_ADR  = 6'h1B;
  localparam logic [7:0] DEF_EICRA_ADR  = 8'h69;
  localparam logic [7:0] DEF_PCICR_ADR  = 8'h68;
  localparam logic [7:0] DEF_PCMSK2_ADR = 8'h6D;

endpackage
`default_nettype wire

// File: rtl/ext_int_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : ext_int_edge_det
// Description : One external interrupt channel (INT0 or INT1). Selects the
//               sensed event from the sense-control field, keeps the INTFn
//               flag and produces the masked interrupt request.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_int_edge_det
  import ext_int_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       pin,
  input  logic       prev,
  input  logic [1:0] isc,
  input  logic       mask,
  input  logic       clr,
  output logic       flag,
  output logic       irq
);

  logic r_flag;
  logic w_set;

  // Select which pin transition sets the flag; level mode never sets it
  always_comb begin
    w_set = 1'b0;
    case (isc)
      ISC_ANY:  w_set = pin ^ prev;
      ISC_FALL: w_set = ~pin & prev;
      ISC_RISE: w_set = pin & ~prev;
      default:  w_set = 1'b0;
    endcase
  end

  // Flag register: a new event beats a concurrent clear so nothing is lost
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag <= 1'b0;
    end else if (w_set) begin
      r_flag <= 1'b1;
    end else if (clr) begin
      r_flag <= 1'b0;
    end
  end

  assign flag = r_flag;
  // Level mode requests straight from the pin; edge modes from the flag
  assign irq  = (isc == ISC_LOW) ? (~pin & mask) : (r_flag & mask);

endmodule
`default_nettype wire

// File: rtl/ext_int_pcint2_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ext_int_pcint2_ctrl
// Description : External interrupt (INT0/INT1) and pin-change interrupt
//               (PCINT[23:16]) controller for Port D. Holds EICRA, EIMSK,
//               EIFR, PCICR, PCIFR and PCMSK2, raises IRQs to the core and
//               returns enable/mask bits to Port D.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_int_pcint2_ctrl
  import ext_int_pkg::*;
#(
  parameter logic [5:0] EIFR_ADR   = DEF_EIFR_ADR,
  parameter logic [5:0] EIMSK_ADR  = DEF_EIMSK_ADR,
  parameter logic [5:0] PCIFR_ADR  = DEF_PCIFR_ADR,
  parameter logic [7:0] EICRA_ADR  = DEF_EICRA_ADR,
  parameter logic [7:0] PCICR_ADR  = DEF_PCICR_ADR,
  parameter logic [7:0] PCMSK2_ADR = DEF_PCMSK2_ADR
) (
  input  logic       cp2,
  input  logic       ireset,
  input  logic [5:0] IO_Addr,
  input  logic       iore,
  input  logic       iowe,
  input  logic [7:0] ram_Addr,
  input  logic       ramre,
  input  logic       ramwe,
  input  logic [7:0] dbus_in,
  output logic [7:0] dbus_out,
  output logic       out_en,
  input  logic [7:0] DID_i,
  input  logic       int0_ack,
  input  logic       int1_ack,
  input  logic       pcint2_ack,
  output logic       int0_irq,
  output logic       int1_irq,
  output logic       pcint2_irq,
  output logic       INT0_EN,
  output logic       INT1_EN,
  output logic       PCIE2,
  output logic [7:0] PCINT
);

  logic [3:0] r_eicra;
  logic [1:0] r_eimsk;
  logic       r_pcie2;
  logic       r_pcif2;
  logic [7:0] r_pcmsk2;
  logic [7:0] r_prev_did;

  logic       w_intf0;
  logic       w_intf1;
  logic       w_wr_eifr;
  logic       w_wr_pcifr;
  logic       w_clr_int0;
  logic       w_clr_int1;
  logic       w_clr_pcif2;
  logic       w_pc_set;

  assign w_wr_eifr   = iowe && (IO_Addr == EIFR_ADR);
  assign w_wr_pcifr  = iowe && (IO_Addr == PCIFR_ADR);
  assign w_clr_int0  = (w_wr_eifr && dbus_in[0]) || int0_ack;
  assign w_clr_int1  = (w_wr_eifr && dbus_in[1]) || int1_ack;
  assign w_clr_pcif2 = (w_wr_pcifr && dbus_in[2]) || pcint2_ack;
  assign w_pc_set    = |((DID_i ^ r_prev_did) & r_pcmsk2);

  // Control registers; only implemented bits are stored
  always_ff @(posedge cp2) begin
    if (ireset) begin
      r_eicra  <= 4'h0;
      r_eimsk  <= 2'b00;
      r_pcie2  <= 1'b0;
      r_pcmsk2 <= 8'h00;
    end else begin
      if (iowe && (IO_Addr == EIMSK_ADR))   r_eimsk  <= dbus_in[1:0];
      if (ramwe && (ram_Addr == EICRA_ADR))  r_eicra  <= dbus_in[3:0];
      if (ramwe && (ram_Addr == PCICR_ADR))  r_pcie2  <= dbus_in[2];
      if (ramwe && (ram_Addr == PCMSK2_ADR)) r_pcmsk2 <= dbus_in;
    end
  end

  // Previous pin sample; loaded during reset so no edge is seen right after
  always_ff @(posedge cp2) begin
    r_prev_did <= DID_i;
  end

  // Pin-change flag: any masked pin toggle sets it, set beats clear
  always_ff @(posedge cp2) begin
    if (ireset) begin
      r_pcif2 <= 1'b0;
    end else if (w_pc_set) begin
      r_pcif2 <= 1'b1;
    end else if (w_clr_pcif2) begin
      r_pcif2 <= 1'b0;
    end
  end

  ext_int_edge_det u_int0 (
    .clk  (cp2),
    .rst  (ireset),
    .pin  (DID_i[2]),
    .prev (r_prev_did[2]),
    .isc  (r_eicra[1:0]),
    .mask (r_eimsk[0]),
    .clr  (w_clr_int0),
    .flag (w_intf0),
    .irq  (int0_irq)
  );

  ext_int_edge_det u_int1 (
    .clk  (cp2),
    .rst  (ireset),
    .pin  (DID_i[3]),
    .prev (r_prev_did[3]),
    .isc  (r_eicra[3:2]),
    .mask (r_eimsk[1]),
    .clr  (w_clr_int1),
    .flag (w_intf1),
    .irq  (int1_irq)
  );

  assign pcint2_irq = r_pcif2 & r_pcie2;
  assign INT0_EN    = r_eimsk[0];
  assign INT1_EN    = r_eimsk[1];
  assign PCIE2      = r_pcie2;
  assign PCINT      = r_pcmsk2;

  // Read mux: I/O-space hits take priority over data-space hits
  always_comb begin
    dbus_out = 8'h00;
    out_en   = 1'b0;
    if (iore && (IO_Addr == EIFR_ADR)) begin
      dbus_out = {6'b0, w_intf1, w_intf0};
      out_en   = 1'b1;
    end else if (iore && (IO_Addr == EIMSK_ADR)) begin
      dbus_out = {6'b0, r_eimsk};
      out_en   = 1'b1;
    end else if (iore && (IO_Addr == PCIFR_ADR)) begin
      dbus_out = {5'b0, r_pcif2, 2'b0};
      out_en   = 1'b1;
    end else if (ramre && (ram_Addr == EICRA_ADR)) begin
      dbus_out = {4'b0, r_eicra};
      out_en   = 1'b1;
    end else if (ramre && (ram_Addr == PCICR_ADR)) begin
      dbus_out = {5'b0, r_pcie2, 2'b0};
      out_en   = 1'b1;
    end else if (ramre && (ram_Addr == PCMSK2_ADR)) begin
      dbus_out = r_pcmsk2;
      out_en   = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ext_int_pcint2_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ext_int_pcint2_ctrl
// Description : Self-checking bench for ext_int_pcint2_ctrl. Directed
//               scenarios followed by randomized traffic, all compared
//               against a behavioural model of the register/flag rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_int_pcint2_ctrl;

  logic       cp2 = 1'b0;
  logic       ireset;
  logic [5:0] IO_Addr;
  logic       iore, iowe;
  logic [7:0] ram_Addr;
  logic       ramre, ramwe;
  logic [7:0] dbus_in;
  logic [7:0] dbus_out;
  logic       out_en;
  logic [7:0] DID_i;
  logic       int0_ack, int1_ack, pcint2_ack;
  logic       int0_irq, int1_irq, pcint2_irq;
  logic       INT0_EN, INT1_EN, PCIE2;
  logic [7:0] PCINT;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int         m_isc [2];
  bit         m_mask[2];
  bit         m_flag[2];
  bit         m_pcie;
  bit         m_pcif;
  logic [7:0] m_pcmsk;
  logic [7:0] m_prev;

  ext_int_pcint2_ctrl dut (
    .cp2(cp2), .ireset(ireset), .IO_Addr(IO_Addr), .iore(iore), .iowe(iowe),
    .ram_Addr(ram_Addr), .ramre(ramre), .ramwe(ramwe), .dbus_in(dbus_in),
    .dbus_out(dbus_out), .out_en(out_en), .DID_i(DID_i),
    .int0_ack(int0_ack), .int1_ack(int1_ack), .pcint2_ack(pcint2_ack),
    .int0_irq(int0_irq), .int1_irq(int1_irq), .pcint2_irq(pcint2_irq),
    .INT0_EN(INT0_EN), .INT1_EN(INT1_EN), .PCIE2(PCIE2), .PCINT(PCINT)
  );

  always #5 cp2 = ~cp2;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit edge_hit(input int mode, input bit was, input bit now);
    case (mode)
      1:       return was != now;
      2:       return was && !now;
      3:       return !was && now;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int pin_of(input int n);
    return (n == 0) ? 2 : 3;
  endfunction

  function automatic bit exp_irq(input int n);
    if (m_isc[n] == 0) return !DID_i[pin_of(n)] && m_mask[n];
    return m_flag[n] && m_mask[n];
  endfunction

  // Compare every observable output against the model's present state
  task automatic check_all();
    int rd;
    int oe;
    rd = 0;
    oe = 0;
    if (iore && IO_Addr == 6'h1C) begin
      oe = 1; rd = m_flag[0] + 2 * m_flag[1];
    end else if (iore && IO_Addr == 6'h1D) begin
      oe = 1; rd = m_mask[0] + 2 * m_mask[1];
    end else if (iore && IO_Addr == 6'h1B) begin
      oe = 1; rd = 4 * m_pcif;
    end else if (ramre && ram_Addr == 8'h69) begin
      oe = 1; rd = m_isc[0] + 4 * m_isc[1];
    end else if (ramre && ram_Addr == 8'h68) begin
      oe = 1; rd = 4 * m_pcie;
    end else if (ramre && ram_Addr == 8'h6D) begin
      oe = 1; rd = m_pcmsk;
    end
    chk("rd_data", dbus_out, 8'(rd));
    chk("rd_en", {7'b0, out_en}, 8'(oe));
    chk("int0_irq", {7'b0, int0_irq}, {7'b0, exp_irq(0)});
    chk("int1_irq", {7'b0, int1_irq}, {7'b0, exp_irq(1)});
    chk("pcint2_irq", {7'b0, pcint2_irq}, {7'b0, m_pcif && m_pcie});
    chk("int0_en", {7'b0, INT0_EN}, {7'b0, m_mask[0]});
    chk("int1_en", {7'b0, INT1_EN}, {7'b0, m_mask[1]});
    chk("pcie2", {7'b0, PCIE2}, {7'b0, m_pcie});
    chk("pcint", PCINT, m_pcmsk);
  endtask

  // Advance the model by one clock edge using the inputs present at the edge
  task automatic model_update();
    bit hit;
    bit clr;
    if (ireset) begin
      for (int n = 0; n < 2; n++) begin
        m_isc[n] = 0; m_mask[n] = 0; m_flag[n] = 0;
      end
      m_pcie = 0; m_pcif = 0; m_pcmsk = 8'h00;
    end else begin
      for (int n = 0; n < 2; n++) begin
        hit = edge_hit(m_isc[n], m_prev[pin_of(n)], DID_i[pin_of(n)]);
        clr = (iowe && IO_Addr == 6'h1C && dbus_in[n]) ||
              (n == 0 ? int0_ack : int1_ack);
        if (hit) m_flag[n] = 1;
        else if (clr) m_flag[n] = 0;
      end
      hit = ((DID_i ^ m_prev) & m_pcmsk) != 8'h00;
      clr = (iowe && IO_Addr == 6'h1B && dbus_in[2]) || pcint2_ack;
      if (hit) m_pcif = 1;
      else if (clr) m_pcif = 0;
      if (iowe && IO_Addr == 6'h1D) begin
        m_mask[0] = dbus_in[0]; m_mask[1] = dbus_in[1];
      end
      if (ramwe && ram_Addr == 8'h69) begin
        m_isc[0] = dbus_in % 4; m_isc[1] = (dbus_in / 4) % 4;
      end
      if (ramwe && ram_Addr == 8'h68) m_pcie = dbus_in[2];
      if (ramwe && ram_Addr == 8'h6D) m_pcmsk = dbus_in;
    end
    m_prev = DID_i;
  endtask

  // One cycle: check at negedge+1, clock, update model, return at negedge
  task automatic step();
    #1 check_all();
    @(posedge cp2);
    model_update();
    @(negedge cp2);
  endtask

  task automatic idle();
    iore = 0; iowe = 0; ramre = 0; ramwe = 0;
    int0_ack = 0; int1_ack = 0; pcint2_ack = 0;
  endtask

  task automatic io_wr(input logic [5:0] a, input logic [7:0] d);
    iowe = 1; IO_Addr = a; dbus_in = d;
    step();
    iowe = 0;
  endtask

  task automatic ram_wr(input logic [7:0] a, input logic [7:0] d);
    ramwe = 1; ram_Addr = a; dbus_in = d;
    step();
    ramwe = 0;
  endtask

  task automatic io_rd(input string tag, input logic [5:0] a, input logic [7:0] exp);
    iore = 1; IO_Addr = a;
    #1 chk(tag, dbus_out, exp);
    step();
    iore = 0;
  endtask

  task automatic ram_rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    ramre = 1; ram_Addr = a;
    #1 chk(tag, dbus_out, exp);
    step();
    ramre = 0;
  endtask

  function automatic logic [5:0] pick_io();
    case ($urandom_range(0, 4))
      0: return 6'h1B;
      1: return 6'h1C;
      2: return 6'h1D;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] pick_ram();
    case ($urandom_range(0, 4))
      0: return 8'h68;
      1: return 8'h69;
      2: return 8'h6D;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    idle();
    IO_Addr = 6'h00; ram_Addr = 8'h00; dbus_in = 8'h00; DID_i = 8'h00;
    m_prev = 8'h00;
    ireset = 1;
    repeat (2) begin
      @(posedge cp2);
      model_update();
    end
    @(negedge cp2);
    ireset = 0;

    // Reset state
    io_rd("rst_eifr", 6'h1C, 8'h00);
    io_rd("rst_eimsk", 6'h1D, 8'h00);
    io_rd("rst_pcifr", 6'h1B, 8'h00);
    ram_rd("rst_eicra", 8'h69, 8'h00);
    ram_rd("rst_pcicr", 8'h68, 8'h00);
    ram_rd("rst_pcmsk2", 8'h6D, 8'h00);
    chk("rst_irqs", {5'b0, int0_irq, int1_irq, pcint2_irq}, 8'h00);
    chk("rst_en", {5'b0, INT0_EN, INT1_EN, PCIE2}, 8'h00);

    // INT0 rising edge, falling edge ignored, write-1 clear
    ram_wr(8'h69, 8'h03);
    io_wr(6'h1D, 8'h01);
    DID_i[2] = 1;
    step();
    #1 chk("t2_irq_set", {7'b0, int0_irq}, 8'h01);
    io_rd("t2_eifr", 6'h1C, 8'h01);
    DID_i[2] = 0;
    step();
    io_rd("t2_fall", 6'h1C, 8'h01);
    io_wr(6'h1C, 8'h01);
    #1 chk("t2_irq_clr", {7'b0, int0_irq}, 8'h00);

    // INT1 level mode
    ram_wr(8'h69, 8'h00);
    io_wr(6'h1D, 8'h02);
    #1 chk("t3_level_irq", {7'b0, int1_irq}, 8'h01);
    io_rd("t3_eifr", 6'h1C, 8'h00);
    DID_i[3] = 1;
    #1 chk("t3_level_off", {7'b0, int1_irq}, 8'h00);
    step();

    // Pin-change group
    ram_wr(8'h68, 8'h04);
    ram_wr(8'h6D, 8'hF0);
    DID_i[0] = ~DID_i[0];
    step();
    io_rd("t4_unmasked", 6'h1B, 8'h00);
    DID_i[7] = ~DID_i[7];
    step();
    io_rd("t4_pcifr", 6'h1B, 8'h04);
    chk("t4_irq", {7'b0, pcint2_irq}, 8'h01);
    chk("t4_pcint", PCINT, 8'hF0);
    pcint2_ack = 1;
    step();
    pcint2_ack = 0;
    #1 chk("t4_ack", {7'b0, pcint2_irq}, 8'h00);

    // Same-cycle clear and new edge: the edge wins
    ram_wr(8'h69, 8'h03);
    io_wr(6'h1D, 8'h01);
    DID_i[2] = 1;
    step();
    DID_i[2] = 0;
    step();
    DID_i[2] = 1;
    iowe = 1; IO_Addr = 6'h1C; dbus_in = 8'h01;
    step();
    iowe = 0;
    io_rd("t5_set_wins", 6'h1C, 8'h01);

    // Pending flag with mask off, then mask on, then reset
    io_wr(6'h1D, 8'h00);
    #1 chk("t6_masked", {7'b0, int0_irq}, 8'h00);
    io_rd("t6_pending", 6'h1C, 8'h01);
    io_wr(6'h1D, 8'h01);
    #1 chk("t6_unmasked", {7'b0, int0_irq}, 8'h01);
    ireset = 1;
    step();
    ireset = 0;
    #1 chk("t6_rst_irq", {7'b0, int0_irq}, 8'h00);
    io_rd("t6_rst_eifr", 6'h1C, 8'h00);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      DID_i      = DID_i ^ 8'($urandom & $urandom);
      iowe       = ($urandom_range(0, 3) == 0);
      iore       = ($urandom_range(0, 1) == 0);
      IO_Addr    = pick_io();
      ramwe      = ($urandom_range(0, 3) == 0);
      ramre      = ($urandom_range(0, 1) == 0);
      ram_Addr   = pick_ram();
      dbus_in    = 8'($urandom);
      int0_ack   = ($urandom_range(0, 7) == 0);
      int1_ack   = ($urandom_range(0, 7) == 0);
      pcint2_ack = ($urandom_range(0, 7) == 0);
      ireset     = ($urandom_range(0, 199) == 0);
      step();
    end
    idle();
    ireset = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
